// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO controller slice: default depth, the
// address-width helper, reset values for the pointers and occupancy, and the
// per-cycle operation encoding used by the occupancy update.
package fifo_pkg;

  localparam int unsigned FIFO_DEFAULT_DEPTH = 4;

  // Reset/flush values for the address counters and the occupancy counter.
  localparam int unsigned ADDR_RST_VAL  = 0;
  localparam int unsigned COUNT_RST_VAL = 0;

  // Address width for a given number of entries. Depth is at least 2, so
  // the result is always at least 1 bit.
  function automatic int unsigned fifo_addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Accepted-operation encoding, bit 1 = write accepted, bit 0 = read accepted.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if
// Handshake and status bundle between the FIFO controller and its users.
//   master : producer/consumer side, drives wr_req, rd_req, clr
//   slave  : fifo_ctrl side, drives memory strobes, addresses and status
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH      = FIFO_DEFAULT_DEPTH,
  parameter int unsigned FIFO_ADDRESS_SIZE = fifo_addr_width(MEMORY_DEPTH)
);

  logic                         wr_req;
  logic                         rd_req;
  logic                         clr;
  logic                         mem_we;
  logic [FIFO_ADDRESS_SIZE-1:0] w_addr;
  logic [FIFO_ADDRESS_SIZE-1:0] r_addr;
  logic                         rd_valid;
  logic                         full;
  logic                         empty;
  logic [FIFO_ADDRESS_SIZE:0]   count;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output wr_req, rd_req, clr,
    input  mem_we, w_addr, r_addr, rd_valid, full, empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, clr,
    output mem_we, w_addr, r_addr, rd_valid, full, empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/wrap_counter.sv
// wrap_counter
// Modulo-MEMORY_DEPTH address counter with a wrap bit that toggles every time
// the address rolls over from MEMORY_DEPTH-1 to 0. The wrap bit lets the
// controller tell full from empty when both addresses are equal.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous flush to zero (wins over inc)
//   inc      : advance the address by one
//   addr     : current address
//   wrap     : wrap parity bit
module wrap_counter
  import fifo_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int unsigned ADDR_W       = fifo_addr_width(MEMORY_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEMORY_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(ADDR_RST_VAL);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;
  logic              en;

  // Explicit roll-over compare so non-power-of-two depths wrap correctly.
  always_comb begin
    addr_d = addr_q;
    wrap_d = wrap_q;
    if (clr) begin
      addr_d = ADDR_RST;
      wrap_d = 1'b0;
    end else if (inc) begin
      if (addr_q == ADDR_LAST) begin
        addr_d = ADDR_RST;
        wrap_d = ~wrap_q;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  assign en = clr | inc;

  // Enable flip-flop: only loads when flushing or advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= ADDR_RST;
      wrap_q <= 1'b0;
    end else if (en) begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Pointer/status controller for the synchronous ALU FIFO. Holds no data;
// sequences the write and read addresses of the external memory, drives its
// write strobe, and reports occupancy, full/empty, a read-valid strobe that
// lines up with the registered memory read, and sticky error flags.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_ctrl_if.slave
//              in  : wr_req, rd_req, clr
//              out : mem_we, w_addr, r_addr, rd_valid, full, empty, count,
//                    overflow, underflow
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH      = FIFO_DEFAULT_DEPTH,
  parameter int unsigned FIFO_ADDRESS_SIZE = fifo_addr_width(MEMORY_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = FIFO_ADDRESS_SIZE + 1;
  localparam logic [CNT_W-1:0] COUNT_RST = CNT_W'(COUNT_RST_VAL);

  logic [FIFO_ADDRESS_SIZE-1:0] w_addr, r_addr;
  logic                         w_wrap, r_wrap;
  logic                         full, empty;
  logic                         wr_acc, rd_acc;
  fifo_op_e                     op;

  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Status comes from the pre-edge pointers, so a write+read while full only
  // takes the read and a write+read while empty only takes the write.
  assign empty = (w_addr == r_addr) && (w_wrap == r_wrap);
  assign full  = (w_addr == r_addr) && (w_wrap != r_wrap);

  // A flush cycle swallows both requests, including the memory strobe.
  assign wr_acc = bus.wr_req & ~full  & ~bus.clr;
  assign rd_acc = bus.rd_req & ~empty & ~bus.clr;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  wrap_counter #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .ADDR_W       (FIFO_ADDRESS_SIZE)
  ) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .inc  (wr_acc),
    .addr (w_addr),
    .wrap (w_wrap)
  );

  wrap_counter #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .ADDR_W       (FIFO_ADDRESS_SIZE)
  ) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .inc  (rd_acc),
    .addr (r_addr),
    .wrap (r_wrap)
  );

  always_comb begin
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q  | (bus.wr_req & full);
    underflow_d = underflow_q | (bus.rd_req & empty);

    unique case (op)
      OP_WR:    count_d = count_q + CNT_W'(1);
      OP_RD:    count_d = count_q - CNT_W'(1);
      OP_IDLE,
      OP_WR_RD: count_d = count_q;
    endcase

    if (bus.clr) begin
      count_d     = COUNT_RST;
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= COUNT_RST;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.mem_we    = wr_acc;
  assign bus.w_addr    = w_addr;
  assign bus.r_addr    = r_addr;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_req = 1'b0, rd_req = 1'b0, clr = 1'b0;
  bit   sel = 1'b0;      // 0 = depth-4 instance, 1 = depth-5 instance
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_ctrl_if #(.MEMORY_DEPTH(4)) if4 ();
  fifo_ctrl_if #(.MEMORY_DEPTH(5)) if5 ();

  assign if4.wr_req = wr_req & ~sel;
  assign if4.rd_req = rd_req & ~sel;
  assign if4.clr    = clr    & ~sel;
  assign if5.wr_req = wr_req &  sel;
  assign if5.rd_req = rd_req &  sel;
  assign if5.clr    = clr    &  sel;

  fifo_ctrl #(.MEMORY_DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  fifo_ctrl #(.MEMORY_DEPTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  // Observed outputs packed as {me, wa[2:0], ra[2:0], rv, full, empty, cnt[3:0], ov, un}
  logic [15:0] obs4, obs5;
  assign obs4 = {if4.mem_we, 1'b0, if4.w_addr, 1'b0, if4.r_addr, if4.rd_valid,
                 if4.full, if4.empty, 1'b0, if4.count, if4.overflow, if4.underflow};
  assign obs5 = {if5.mem_we, if5.w_addr, if5.r_addr, if5.rd_valid,
                 if5.full, if5.empty, if5.count, if5.overflow, if5.underflow};

  typedef struct {
    int          cyc;
    bit          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] pk(bit me, int wa, int ra, bit rv, bit f, bit e,
                                     int c, bit o, bit u);
    return {me, 3'(wa), 3'(ra), rv, f, e, 4'(c), o, u};
  endfunction

  // One cycle of stimulus plus the outputs expected during that cycle
  // (state from earlier edges, mem_we from this cycle's requests).
  task automatic row(string name, bit s, bit r, bit w, bit rq, bit c,
                     bit me, int wa, int ra, bit rv, bit f, bit e,
                     int cnt, bit o, bit u);
    exp_t x;
    @(posedge clk);
    #1;
    sel = s; rst = r; wr_req = w; rd_req = rq; clr = c;
    x.cyc  = cyc;
    x.sel  = s;
    x.exp  = pk(me, wa, ra, rv, f, e, cnt, o, u);
    x.name = name;
    sb.push_back(x);
  endtask

  // Monitor: compares whatever expectation is due at this cycle's mid-point.
  exp_t        mx;
  logic [15:0] got;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mx  = sb.pop_front();
      got = mx.sel ? obs5 : obs4;
      total++;
      if (mx.cyc != cyc) begin
        bad++;
        $display("FAIL %s: check at cycle %0d, required cycle %0d", mx.name, cyc, mx.cyc);
      end else if (got !== mx.exp) begin
        bad++;
        $display("FAIL %s: got=%b required=%b (me wa ra rv f e cnt ov un)",
                 mx.name, got, mx.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        name         s  rst wr rd clr   me wa ra rv f  e  cnt o  u
    row("reset",           0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,  0, 0);
    row("wr1",             0, 0, 1, 0, 0,    1, 0, 0, 0, 0, 1, 0,  0, 0);
    row("wr2",             0, 0, 1, 0, 0,    1, 1, 0, 0, 0, 0, 1,  0, 0);
    row("wr3",             0, 0, 1, 0, 0,    1, 2, 0, 0, 0, 0, 2,  0, 0);
    row("wr4",             0, 0, 1, 0, 0,    1, 3, 0, 0, 0, 0, 3,  0, 0);
    row("wr5_full",        0, 0, 1, 0, 0,    0, 0, 0, 0, 1, 0, 4,  0, 0);
    row("ovf_set",         0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 4,  1, 0);
    row("rd_full",         0, 0, 0, 1, 0,    0, 0, 0, 0, 1, 0, 4,  1, 0);
    row("rd_valid",        0, 0, 0, 0, 0,    0, 0, 1, 1, 0, 0, 3,  1, 0);
    row("wr_rd_c3",        0, 0, 1, 1, 0,    1, 0, 1, 0, 0, 0, 3,  1, 0);
    row("after_wr_rd",     0, 0, 0, 0, 0,    0, 1, 2, 1, 0, 0, 3,  1, 0);
    row("drain1",          0, 0, 0, 1, 0,    0, 1, 2, 0, 0, 0, 3,  1, 0);
    row("drain2",          0, 0, 0, 1, 0,    0, 1, 3, 1, 0, 0, 2,  1, 0);
    row("drain3_wrap",     0, 0, 0, 1, 0,    0, 1, 0, 1, 0, 0, 1,  1, 0);
    row("empty",           0, 0, 0, 0, 0,    0, 1, 1, 1, 0, 1, 0,  1, 0);
    row("rd_empty",        0, 0, 0, 1, 0,    0, 1, 1, 0, 0, 1, 0,  1, 0);
    row("unf_set",         0, 0, 0, 0, 0,    0, 1, 1, 0, 0, 1, 0,  1, 1);
    row("wr_rd_empty",     0, 0, 1, 1, 0,    1, 1, 1, 0, 0, 1, 0,  1, 1);
    row("only_wr_taken",   0, 0, 0, 0, 0,    0, 2, 1, 0, 0, 0, 1,  1, 1);
    row("fill_a",          0, 0, 1, 0, 0,    1, 2, 1, 0, 0, 0, 1,  1, 1);
    row("fill_b",          0, 0, 1, 0, 0,    1, 3, 1, 0, 0, 0, 2,  1, 1);
    row("clr_cycle",       0, 0, 1, 1, 1,    0, 0, 1, 0, 0, 0, 3,  1, 1);
    row("after_clr",       0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,  0, 0);
    row("rs_wr1",          0, 0, 1, 0, 0,    1, 0, 0, 0, 0, 1, 0,  0, 0);
    row("rs_wr2",          0, 0, 1, 0, 0,    1, 1, 0, 0, 0, 0, 1,  0, 0);
    row("rs_wr3",          0, 0, 1, 0, 0,    1, 2, 0, 0, 0, 0, 2,  0, 0);
    row("rs_rd",           0, 0, 0, 1, 0,    0, 3, 0, 0, 0, 0, 3,  0, 0);
    row("rst_mid",         0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,  0, 0);
    row("rst_release",     0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,  0, 0);
    row("wr_after_rst",    0, 0, 1, 0, 0,    1, 0, 0, 0, 0, 1, 0,  0, 0);

    // Depth-5 instance: steady full-rate streaming across non-power-of-two wraps.
    row("d5_wr1",          1, 0, 1, 0, 0,    1, 0, 0, 0, 0, 1, 0,  0, 0);
    row("d5_wr2",          1, 0, 1, 0, 0,    1, 1, 0, 0, 0, 0, 1,  0, 0);
    for (int i = 0; i < 10; i++)
      row($sformatf("d5_stream%0d", i), 1, 0, 1, 1, 0,
          1, (2 + i) % 5, i % 5, (i > 0), 0, 0, 2, 0, 0);
    row("d5_stream_end",   1, 0, 0, 0, 0,    0, 2, 0, 1, 0, 0, 2,  0, 0);
    row("d5_fill3",        1, 0, 1, 0, 0,    1, 2, 0, 0, 0, 0, 2,  0, 0);
    row("d5_fill4",        1, 0, 1, 0, 0,    1, 3, 0, 0, 0, 0, 3,  0, 0);
    row("d5_fill5",        1, 0, 1, 0, 0,    1, 4, 0, 0, 0, 0, 4,  0, 0);
    row("d5_wr_full",      1, 0, 1, 0, 0,    0, 0, 0, 0, 1, 0, 5,  0, 0);
    row("d5_ovf",          1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 5,  1, 0);
    row("d5_wr_rd_full",   1, 0, 1, 1, 0,    0, 0, 0, 0, 1, 0, 5,  1, 0);
    row("d5_only_rd",      1, 0, 0, 0, 0,    0, 0, 1, 1, 0, 0, 4,  1, 0);

    repeat (3) @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
